// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types for the cache-side AXI read arbiter and its round-robin picker.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } arb_state_t;

    localparam logic [2:0] AXI_SIZE_1B = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;

    localparam int AXI_ADDR_W = 32;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] araddr;
        logic [7:0]            arlen;
        logic [2:0]            arsize;
    } axi_ar_req_t;

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', as one-hot and index.
module rr_pick #(
    parameter  int N     = 2,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] index
);

    logic found;
    int   cand;

    // Scan starting one past the previous winner so the search order rotates.
    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                index        = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel between the L1 caches; one burst outstanding at a time,
// round-robin grant held from AR handshake through the rlast beat.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter  int NR_MASTERS = 2,
    parameter  int LEN_ADDR   = 32,
    parameter  int LEN_DATA   = 32,
    localparam int IDX_W      = $clog2(NR_MASTERS)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [LEN_ADDR-1:0]   m_araddr [NR_MASTERS],
    input  logic [7:0]            m_arlen  [NR_MASTERS],
    input  logic [2:0]            m_arsize [NR_MASTERS],
    input  logic [NR_MASTERS-1:0] m_arvalid,
    output logic [NR_MASTERS-1:0] m_arready,
    output logic [LEN_DATA-1:0]   m_rdata  [NR_MASTERS],
    output logic [NR_MASTERS-1:0] m_rlast,
    output logic [NR_MASTERS-1:0] m_rvalid,
    input  logic [NR_MASTERS-1:0] m_rready,

    output logic [LEN_ADDR-1:0]   s_araddr,
    output logic [7:0]            s_arlen,
    output logic [2:0]            s_arsize,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [LEN_DATA-1:0]   s_rdata,
    input  logic                  s_rlast,
    input  logic                  s_rvalid,
    output logic                  s_rready,

    output logic [IDX_W-1:0]      grant_id,
    output logic                  proto_err
);

    arb_state_t             state;
    logic [IDX_W-1:0]       grant;
    logic [NR_MASTERS-1:0]  grant_oh;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic [NR_MASTERS-1:0]  pick_oh;
    logic [7:0]             len_q;
    logic [8:0]             beat_cnt;
    logic                   ar_fire;
    logic                   r_fire;

    rr_pick #(
        .N(NR_MASTERS)
    ) u_pick (
        .req    (m_arvalid),
        .last   (last_grant),
        .onehot (pick_oh),
        .index  (pick_idx)
    );

    assign ar_fire  = (state == ADDR) && s_arvalid && s_arready;
    assign r_fire   = (state == DATA) && s_rvalid && s_rready;
    assign grant_id = grant;

    // Outputs decode from the registered state so a reset blanks them in the same cycle.
    always_comb begin
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_rready  = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rlast   = '0;
        for (int i = 0; i < NR_MASTERS; i++) begin
            m_rdata[i] = '0;
        end
        case (state)
            ADDR: begin
                s_arvalid = m_arvalid[grant];
                s_araddr  = m_araddr[grant];
                s_arlen   = m_arlen[grant];
                s_arsize  = m_arsize[grant];
                m_arready = grant_oh & {NR_MASTERS{s_arready}};
            end
            DATA: begin
                s_rready = m_rready[grant];
                m_rvalid = grant_oh & {NR_MASTERS{s_rvalid}};
                m_rlast  = grant_oh & {NR_MASTERS{s_rlast}};
                for (int i = 0; i < NR_MASTERS; i++) begin
                    m_rdata[i] = s_rdata;
                end
            end
            default: ;
        endcase
    end

    // The burst only ever ends on rlast; a count disagreement is flagged but never truncates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            grant_oh   <= '0;
            last_grant <= IDX_W'(NR_MASTERS - 1);
            len_q      <= '0;
            beat_cnt   <= '0;
            proto_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_arvalid) begin
                        grant    <= pick_idx;
                        grant_oh <= pick_oh;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_fire) begin
                        len_q    <= m_arlen[grant];
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (r_fire) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (s_rlast) begin
                            if (beat_cnt != {1'b0, len_q}) begin
                                proto_err <= 1'b1;
                            end
                            last_grant <= grant;
                            state      <= IDLE;
                        end else if (beat_cnt == {1'b0, len_q}) begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
